// File: rtl/eth_mac_stats_pkg.sv
// Shared constants for the Ethernet MAC statistics counter block: event
// index map and the error-event mask used by the optional threshold interrupt.
package eth_mac_stats_pkg;

    localparam int NUM_EVENTS = 9;

    localparam int EVT_TX_UNDERFLOW    = 0;
    localparam int EVT_TX_FIFO_OVF     = 1;
    localparam int EVT_TX_FIFO_BAD     = 2;
    localparam int EVT_TX_FIFO_GOOD    = 3;
    localparam int EVT_RX_BAD_FRAME    = 4;
    localparam int EVT_RX_BAD_FCS      = 5;
    localparam int EVT_RX_FIFO_OVF     = 6;
    localparam int EVT_RX_FIFO_BAD     = 7;
    localparam int EVT_RX_FIFO_GOOD    = 8;

    // Events 0, 1, 5 and 6 are the error classes that may raise irq.
    localparam logic [NUM_EVENTS-1:0] ERR_EVT_MASK = 9'b001100011;

    function automatic logic is_err_event(input int evt_idx);
        logic [3:0] idx4;
        idx4 = 4'(evt_idx);
        return ERR_EVT_MASK[idx4];
    endfunction

endpackage

// File: rtl/eth_mac_stats_cell.sv
// One statistics counter: increment, saturate or wrap at full scale,
// clear-on-read merged with a same-cycle event, and all-ones detection.
module eth_mac_stats_cell #(
    parameter int COUNT_WIDTH = 32,
    parameter int SATURATE    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inc,
    input  logic                   clr_all,
    input  logic                   rd_clr,
    output logic [COUNT_WIDTH-1:0] cnt,
    output logic                   at_max
);

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    logic [COUNT_WIDTH-1:0] cnt_q;
    logic [COUNT_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_all) begin
            cnt_d = '0;
        end else if (rd_clr) begin
            // A pulse landing on the clearing read is kept as the first new count.
            cnt_d = inc ? COUNT_WIDTH'(1) : '0;
        end else if (inc) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = (SATURATE != 0) ? CNT_MAX : '0;
            end else begin
                cnt_d = cnt_q + COUNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt    = cnt_q;
    assign at_max = (cnt_d == CNT_MAX);

endmodule

// File: rtl/eth_mac_stats_counters.sv
// PORTS x 9 MAC status-pulse counters with a 1-cycle request/ack read port.
// Optional threshold interrupt enabled by defining ETH_STATS_THRESH_EN.
module eth_mac_stats_counters
    import eth_mac_stats_pkg::*;
#(
    parameter int PORTS          = 4,
    parameter int COUNT_WIDTH    = 32,
    parameter int SATURATE       = 1,
    parameter int PORT_SEL_WIDTH = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS*NUM_EVENTS-1:0] evt,
    input  logic                        clr_all,
    input  logic                        rd_req,
    input  logic [PORT_SEL_WIDTH-1:0]   rd_port,
    input  logic [3:0]                  rd_sel,
    input  logic                        rd_clear,
`ifdef ETH_STATS_THRESH_EN
    input  logic [COUNT_WIDTH-1:0]      thresh,
    output logic                        irq,
`endif
    output logic                        rd_ack,
    output logic [COUNT_WIDTH-1:0]      rd_data,
    output logic [PORTS-1:0]            sat_flag
);

    localparam int NCNT = PORTS * NUM_EVENTS;

    logic [COUNT_WIDTH-1:0] cnt [NCNT];
    logic [NCNT-1:0]        cell_max;
    logic [NCNT-1:0]        rd_clr_vec;
    logic                   rd_in_range;
    int                     rd_idx;
    logic [COUNT_WIDTH-1:0] rd_mux;

    logic                   rd_ack_q, rd_ack_d;
    logic [COUNT_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [PORTS-1:0]       sat_flag_q, sat_flag_d;

    genvar gi;
    generate
        for (gi = 0; gi < NCNT; gi++) begin : g_cell
            eth_mac_stats_cell #(
                .COUNT_WIDTH(COUNT_WIDTH),
                .SATURATE   (SATURATE)
            ) u_cell (
                .clk    (clk),
                .rst    (rst),
                .inc    (evt[gi]),
                .clr_all(clr_all),
                .rd_clr (rd_clr_vec[gi]),
                .cnt    (cnt[gi]),
                .at_max (cell_max[gi])
            );
        end
    endgenerate

    // Out-of-range addresses neither select nor clear any counter.
    always_comb begin
        rd_in_range = (int'(rd_port) < PORTS) && (int'(rd_sel) < NUM_EVENTS);
        rd_idx      = int'(rd_port) * NUM_EVENTS + int'(rd_sel);
        rd_mux      = '0;
        rd_clr_vec  = '0;
        for (int i = 0; i < NCNT; i++) begin
            if (rd_in_range && (rd_idx == i)) begin
                rd_mux        = cnt[i];
                rd_clr_vec[i] = rd_req & rd_clear;
            end
        end
    end

    always_comb begin
        rd_ack_d   = rd_req;
        rd_data_d  = rd_req ? rd_mux : rd_data_q;
        sat_flag_d = sat_flag_q;
        if (clr_all) begin
            sat_flag_d = '0;
        end else begin
            for (int p = 0; p < PORTS; p++) begin
                for (int e = 0; e < NUM_EVENTS; e++) begin
                    if (cell_max[p*NUM_EVENTS+e]) begin
                        sat_flag_d[p] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ack_q   <= 1'b0;
            rd_data_q  <= '0;
            sat_flag_q <= '0;
        end else begin
            rd_ack_q   <= rd_ack_d;
            rd_data_q  <= rd_data_d;
            sat_flag_q <= sat_flag_d;
        end
    end

    assign rd_ack   = rd_ack_q;
    assign rd_data  = rd_data_q;
    assign sat_flag = sat_flag_q;

`ifdef ETH_STATS_THRESH_EN
    logic irq_q, irq_d;
    logic err_hit;

    always_comb begin
        err_hit = 1'b0;
        for (int i = 0; i < NCNT; i++) begin
            if (is_err_event(i % NUM_EVENTS) && (cnt[i] >= thresh)) begin
                err_hit = 1'b1;
            end
        end
        irq_d = irq_q | (err_hit && (thresh != '0));
        if (clr_all) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_eth_mac_stats_counters.sv
// Scoreboard bench for eth_mac_stats_counters: one saturating and one wrapping
// 8-bit instance driven in lockstep against a behavioural counter model.
module tb_eth_mac_stats_counters;
    import eth_mac_stats_pkg::*;

    localparam int PORTS = 4;
    localparam int CW    = 8;
    localparam int PSW   = 3;
    localparam int NC    = PORTS * NUM_EVENTS;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NC-1:0]   evt = '0;
    logic            clr_all = 1'b0;
    logic            rd_req = 1'b0;
    logic [PSW-1:0]  rd_port = '0;
    logic [3:0]      rd_sel = '0;
    logic            rd_clear = 1'b0;
    logic            ack_s, ack_w;
    logic [CW-1:0]   data_s, data_w;
    logic [PORTS-1:0] sat_s, sat_w;
`ifdef ETH_STATS_THRESH_EN
    logic [CW-1:0]   thresh = '0;
    logic            irq_s, irq_w;
`endif

    always #5 clk = ~clk;

    eth_mac_stats_counters #(.PORTS(PORTS), .COUNT_WIDTH(CW), .SATURATE(1), .PORT_SEL_WIDTH(PSW)) u_sat (
        .clk(clk), .rst(rst), .evt(evt), .clr_all(clr_all), .rd_req(rd_req),
        .rd_port(rd_port), .rd_sel(rd_sel), .rd_clear(rd_clear),
`ifdef ETH_STATS_THRESH_EN
        .thresh(thresh), .irq(irq_s),
`endif
        .rd_ack(ack_s), .rd_data(data_s), .sat_flag(sat_s));

    eth_mac_stats_counters #(.PORTS(PORTS), .COUNT_WIDTH(CW), .SATURATE(0), .PORT_SEL_WIDTH(PSW)) u_wrap (
        .clk(clk), .rst(rst), .evt(evt), .clr_all(clr_all), .rd_req(rd_req),
        .rd_port(rd_port), .rd_sel(rd_sel), .rd_clear(rd_clear),
`ifdef ETH_STATS_THRESH_EN
        .thresh(thresh), .irq(irq_w),
`endif
        .rd_ack(ack_w), .rd_data(data_w), .sat_flag(sat_w));

    typedef struct {
        int          due;
        logic [7:0]  ds;
        logic [7:0]  dw;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic       rst_s = 1'b1;
    bit         mon_en = 1'b0;
    int         ms[NC];
    int         mw[NC];
    logic [PORTS-1:0] sfs = '0;
    logic [PORTS-1:0] sfw = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        rst_s = rst;
    end

    // Output monitor: pops one expectation per acked read, otherwise expects idle/hold.
    initial begin : monitor
        exp_t e;
        logic [7:0] last_s, last_w;
        last_s = '0;
        last_w = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (rst_s) begin
                    check_eq($sformatf("rst_ack_s@%0d", cyc), ack_s, 1'b0);
                    check_eq($sformatf("rst_ack_w@%0d", cyc), ack_w, 1'b0);
                    check_eq($sformatf("rst_data_s@%0d", cyc), data_s, 8'h00);
                    check_eq($sformatf("rst_data_w@%0d", cyc), data_w, 8'h00);
                    last_s = '0;
                    last_w = '0;
                end else if (sb.size() > 0 && sb[0].due == cyc) begin
                    e = sb.pop_front();
                    check_eq($sformatf("ack_s@%0d", cyc), ack_s, 1'b1);
                    check_eq($sformatf("ack_w@%0d", cyc), ack_w, 1'b1);
                    check_eq($sformatf("rd_data_s@%0d", cyc), data_s, e.ds);
                    check_eq($sformatf("rd_data_w@%0d", cyc), data_w, e.dw);
                    last_s = e.ds;
                    last_w = e.dw;
                end else begin
                    check_eq($sformatf("idle_ack_s@%0d", cyc), ack_s, 1'b0);
                    check_eq($sformatf("idle_ack_w@%0d", cyc), ack_w, 1'b0);
                    check_eq($sformatf("hold_data_s@%0d", cyc), data_s, last_s);
                    check_eq($sformatf("hold_data_w@%0d", cyc), data_w, last_w);
                end
            end
        end
    end

    task automatic model_zero();
        for (int i = 0; i < NC; i++) begin
            ms[i] = 0;
            mw[i] = 0;
        end
        sfs = '0;
        sfw = '0;
    endtask

    task automatic step(input logic [NC-1:0] ev, input logic req, input int port,
                        input int sel, input logic rclr, input logic ca);
        exp_t e;
        bit   in_rng;
        int   idx;
        evt      = ev;
        rd_req   = req;
        rd_port  = PSW'(port);
        rd_sel   = 4'(sel);
        rd_clear = rclr;
        clr_all  = ca;
        in_rng = (port < PORTS) && (sel < NUM_EVENTS);
        idx    = port * NUM_EVENTS + sel;
        if (req) begin
            e.due = cyc + 1;
            e.ds  = in_rng ? 8'(ms[idx]) : 8'h00;
            e.dw  = in_rng ? 8'(mw[idx]) : 8'h00;
            sb.push_back(e);
        end
        if (ca) begin
            model_zero();
        end else begin
            for (int i = 0; i < NC; i++) begin
                if (req && rclr && in_rng && i == idx) begin
                    ms[i] = int'(ev[i]);
                    mw[i] = int'(ev[i]);
                end else if (ev[i]) begin
                    ms[i] = (ms[i] == 255) ? 255 : ms[i] + 1;
                    mw[i] = (mw[i] == 255) ? 0 : mw[i] + 1;
                end
                if (ms[i] == 255) sfs[i / NUM_EVENTS] = 1'b1;
                if (mw[i] == 255) sfw[i / NUM_EVENTS] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        evt      = '0;
        rd_req   = 1'b0;
        rd_clear = 1'b0;
        clr_all  = 1'b0;
    endtask

    task automatic rd(input int port, input int sel, input logic rclr);
        step('0, 1'b1, port, sel, rclr, 1'b0);
    endtask

    task automatic pulse(input int bit_idx, input int n);
        logic [NC-1:0] v;
        v = '0;
        v[bit_idx] = 1'b1;
        repeat (n) step(v, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic sweep();
        for (int p = 0; p < PORTS; p++) begin
            for (int s = 0; s < NUM_EVENTS; s++) begin
                rd(p, s, 1'b0);
            end
        end
    endtask

    initial begin : stim
        logic [NC-1:0] v;
        model_zero();
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        check_eq("reset_sat_s", sat_s, 4'b0000);
        check_eq("reset_sat_w", sat_w, 4'b0000);

        pulse(EVT_RX_BAD_FRAME, 5);
        sweep();

        pulse(1 * NUM_EVENTS + EVT_RX_FIFO_GOOD, 300);
        rd(1, 8, 1'b0);
        check_eq("sat_flag_s_full", sat_s, 4'b0010);
        check_eq("sat_flag_w_full", sat_w, 4'b0010);

        step('0, 1'b1, 1, 8, 1'b0, 1'b1);
        check_eq("sat_flag_s_clr", sat_s, 4'b0000);
        check_eq("sat_flag_w_clr", sat_w, 4'b0000);
        rd(1, 8, 1'b0);

        pulse(2 * NUM_EVENTS + 3, 10);
        v = '0;
        v[2 * NUM_EVENTS + 3] = 1'b1;
        step(v, 1'b1, 2, 3, 1'b1, 1'b0);
        rd(2, 3, 1'b0);
        rd(2, 3, 1'b1);
        rd(2, 3, 1'b0);

        step('0, 1'b0, 0, 0, 1'b0, 1'b1);
        repeat (7) step('1, 1'b0, 0, 0, 1'b0, 1'b0);
        sweep();

        step('0, 1'b1, 5, 2, 1'b1, 1'b0);
        step('0, 1'b1, 0, 12, 1'b1, 1'b0);
        step('0, 1'b1, 4, 0, 1'b1, 1'b0);
        sweep();

        v = '0;
        v[0] = 1'b1;
        step(v, 1'b1, 0, 0, 1'b0, 1'b0);
        rd(0, 0, 1'b0);

        rst = 1'b1;
        rd_req = 1'b1;
        rd_port = '0;
        rd_sel = 4'd0;
        model_zero();
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd_req = 1'b0;
        rd(0, 0, 1'b0);
        check_eq("sat_after_rst_s", sat_s, 4'b0000);

`ifdef ETH_STATS_THRESH_EN
        repeat (3) step('1, 1'b0, 0, 0, 1'b0, 1'b0);
        step('0, 1'b0, 0, 0, 1'b0, 1'b0);
        check_eq("irq_s_thresh0", irq_s, 1'b0);
        step('0, 1'b0, 0, 0, 1'b0, 1'b1);
        thresh = 8'd3;
        pulse(3 * NUM_EVENTS + EVT_TX_FIFO_OVF, 3);
        check_eq("irq_s_at_third", irq_s, 1'b0);
        check_eq("irq_w_at_third", irq_w, 1'b0);
        step('0, 1'b0, 0, 0, 1'b0, 1'b0);
        check_eq("irq_s_rise", irq_s, 1'b1);
        check_eq("irq_w_rise", irq_w, 1'b1);
        step('0, 1'b0, 0, 0, 1'b0, 1'b1);
        check_eq("irq_s_clr", irq_s, 1'b0);
        check_eq("irq_w_clr", irq_w, 1'b0);
        rd(3, 1, 1'b0);
`endif

        step('0, 1'b0, 0, 0, 1'b0, 1'b0);
        step('0, 1'b0, 0, 0, 1'b0, 1'b0);
        check_eq("sb_drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
